mc_rd_fifo_gen: RTL

MC_RD_FIFO_GEN -- requirements
Module: mc_rd_fifo_gen

---
 rtl/mc_rd_fifo_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/mc_rd_fifo_gen.sv
// First-word-fall-through FIFO with sticky overflow/underflow flags and occupancy count.
// Optional per-entry even parity when MC_RD_FIFO_PARITY_EN is defined.
module mc_rd_fifo_gen #(
  parameter int DW     = 36,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [DW-1:0]              din,
  input  logic                       we,
  input  logic                       re,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic                       full,
  output logic                       afull,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       udf,
  output logic                       par_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef MC_RD_FIFO_PARITY_EN
  localparam int EW = DW + 1;
`else
  localparam int EW = DW;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [EW-1:0] wdata, head;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign afull = (count >= CW'(AF_LVL));

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign push = we & (~full | re) & ~clr;
  assign pop  = re & ~empty & ~clr;

`ifdef MC_RD_FIFO_PARITY_EN
  assign wdata   = {^din, din};
`else
  assign wdata   = din;
`endif

  assign head = mem[rd_ptr];
  assign dout = empty ? '0 : head[DW-1:0];

`ifdef MC_RD_FIFO_PARITY_EN
  assign par_err = ~empty & (head[DW] != ^head[DW-1:0]);
`else
  assign par_err = 1'b0;
`endif

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (we && full && !re) ovf <= 1'b1;
      if (re && empty)       udf <= 1'b1;
    end
  end

endmodule
